fifo_wr_rr_arbiter: RTL

//  Shares the single write port of one sync_fifo among NUM_REQ requesters.
//  - Each requester has a valid/ready handshake.
//  - Round-robin arbitration, burst-limited: the owner keeps the grant for up to MAX_BURST beats.
//  - Sits between producer blocks and the FIFO's wr_en/wr_data/full pins.
//  - Guarantees no write is presented while the FIFO is full, and no starvation.

---
 rtl/fifo_arb_pkg.sv | 24 ++
 rtl/rr_priority_sel.sv | 31 +++
 rtl/fifo_wr_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port round-robin arbiter.
// Build option: FIFO_ARB_SRC_TAG_EN widens the FIFO write word with the source id.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of a requester index.
    function automatic int unsigned id_w(input int unsigned n);
        return $clog2(n);
    endfunction

    // Width of the word presented on the FIFO write port.
    function automatic int unsigned out_w(input int unsigned num_req, input int unsigned data_width);
`ifdef FIFO_ARB_SRC_TAG_EN
        return id_w(num_req) + data_width;
`else
        return (num_req > 0) ? data_width : data_width;
`endif
    endfunction

endpackage

// File: rtl/rr_priority_sel.sv
// Round-robin priority selector: first set request bit after ptr, wrapping.
module rr_priority_sel
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]          req,
    input  logic [id_w(NUM_REQ)-1:0]    ptr,
    output logic                        found,
    output logic [id_w(NUM_REQ)-1:0]    idx
);

    localparam int unsigned IDW = id_w(NUM_REQ);

    logic [IDW-1:0] cand;

    // Scan ptr+1, ptr+2, ... ptr+NUM_REQ (mod NUM_REQ); ptr itself is checked last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Burst-limited round-robin arbiter sharing one sync_fifo write port among
// NUM_REQ valid/ready requesters. Never writes while the FIFO is full.
// Build option: FIFO_ARB_SRC_TAG_EN prepends the owner id to fifo_wr_data.
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          req_data,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic                                   fifo_wr_en,
    output logic [out_w(NUM_REQ,DATA_WIDTH)-1:0]   fifo_wr_data,
    input  logic                                   fifo_full,
    output logic                                   grant_valid,
    output logic [id_w(NUM_REQ)-1:0]               grant_id
);

    localparam int unsigned IDW = id_w(NUM_REQ);
    localparam int unsigned BW  = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    arb_state_e            state, state_nxt;
    logic [IDW-1:0]        owner;
    logic [IDW-1:0]        rr_ptr;
    logic [BW-1:0]         burst_cnt;
    logic                  sel_found;
    logic [IDW-1:0]        sel_idx;
    logic                  owner_valid;
    logic [DATA_WIDTH-1:0] owner_data;
    logic                  beat;
    logic                  rel;

    rr_priority_sel #(
        .NUM_REQ (NUM_REQ)
    ) u_sel (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (sel_found),
        .idx   (sel_idx)
    );

    // Owner-side decode: its valid, its payload, whether a beat moves, and release.
    always_comb begin
        owner_valid = req_valid[owner];
        owner_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (owner == IDW'(i)) begin
                owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        beat = (state == GRANT) && owner_valid && !fifo_full;
        rel  = (state == GRANT) && (!owner_valid || (beat && (burst_cnt == LAST_BEAT)));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one arbitration cycle in IDLE, stay in GRANT until released.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sel_found) state_nxt = GRANT;
            GRANT:   if (rel)       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Owner, round-robin pointer and burst counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (sel_found) begin
                owner     <= sel_idx;
                burst_cnt <= '0;
            end
        end else if (rel) begin
            rr_ptr    <= owner;
            burst_cnt <= '0;
        end else if (beat) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Output decode: everything is 0 outside GRANT.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        grant_valid  = 1'b0;
        grant_id     = '0;
        if (state == GRANT) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (owner == IDW'(i)) && !fifo_full;
            end
            fifo_wr_en  = beat;
            grant_valid = 1'b1;
            grant_id    = owner;
`ifdef FIFO_ARB_SRC_TAG_EN
            fifo_wr_data = {owner, owner_data};
`else
            fifo_wr_data = owner_data;
`endif
        end
    end

endmodule
